rr_grant_seq4: RTL

Four-requester round-robin grant sequencer that produces the 2-bit binary index consumed by the downstream `pdecoder2to4` stage. Each grant is held until the owning requester signals completion. The one-hot select for the shared resource is then produced by the decoder, which turns `gnt_idx` into a 4-bit select. Fairness is strict rotation: the pointer advances to one past the last granted index.

---
 rtl/rr_grant_seq4_if.sv | 24 ++
 rtl/rr_grant_seq4.sv | 111 +++++++++++
 2 files changed

// File: rtl/rr_grant_seq4_if.sv
// Grant handshake bundle between the four requesters and the rr_grant_seq4 sequencer.
interface rr_grant_seq4_if;
  logic [3:0] req;
  logic       done;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout_flag;

  modport master (
    output req,
    output done,
    input  gnt_idx,
    input  gnt_valid,
    input  timeout_flag
  );

  modport slave (
    input  req,
    input  done,
    output gnt_idx,
    output gnt_valid,
    output timeout_flag
  );
endinterface

// File: rtl/rr_grant_seq4.sv
// Four-requester round-robin grant sequencer producing a held 2-bit grant index.
// Optional grant watchdog is compiled in with `define RR_GRANT_SEQ4_TIMEOUT_EN.
module rr_grant_seq4 #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic          clk,
  input  logic          rst,
  rr_grant_seq4_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("rr_grant_seq4: TIMEOUT_CYCLES must be in 2..65535");
  end

  // Returns {found, index}: first set bit of r scanning upward from p, wrapping mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] rel_ptr_c;
  logic [2:0] idle_pick_c;
  logic [2:0] rel_pick_c;
  logic       expire_c;
  logic       release_c;

`ifdef RR_GRANT_SEQ4_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] wdog_cnt;

  assign expire_c = (wdog_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) && !bus.done;
`else
  assign expire_c = 1'b0;
  assign bus.timeout_flag = 1'b0;
`endif

  // Arbitration candidates: fresh scan from ptr in IDLE, from the owner's successor on release.
  always_comb begin
    rel_ptr_c   = bus.gnt_idx + 2'd1;
    idle_pick_c = rr_pick(bus.req, ptr);
    rel_pick_c  = rr_pick(bus.req, rel_ptr_c);
    release_c   = (state == GRANT) && (bus.done || expire_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= 2'd0;
      bus.gnt_idx   <= 2'd0;
      bus.gnt_valid <= 1'b0;
`ifdef RR_GRANT_SEQ4_TIMEOUT_EN
      wdog_cnt         <= '0;
      bus.timeout_flag <= 1'b0;
`endif
    end else begin
`ifdef RR_GRANT_SEQ4_TIMEOUT_EN
      bus.timeout_flag <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (idle_pick_c[2]) begin
            bus.gnt_idx   <= idle_pick_c[1:0];
            bus.gnt_valid <= 1'b1;
            state         <= GRANT;
`ifdef RR_GRANT_SEQ4_TIMEOUT_EN
            wdog_cnt      <= '0;
`endif
          end
        end
        GRANT: begin
          if (release_c) begin
            // Back-to-back re-grant when anyone is still requesting; owner ranks last.
            ptr <= rel_ptr_c;
            if (rel_pick_c[2]) begin
              bus.gnt_idx <= rel_pick_c[1:0];
            end else begin
              bus.gnt_valid <= 1'b0;
              state         <= IDLE;
            end
`ifdef RR_GRANT_SEQ4_TIMEOUT_EN
            wdog_cnt         <= '0;
            bus.timeout_flag <= expire_c;
`endif
          end else begin
`ifdef RR_GRANT_SEQ4_TIMEOUT_EN
            wdog_cnt <= wdog_cnt + CNT_W'(1);
`endif
          end
        end
        default: begin
          state         <= IDLE;
          bus.gnt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
